// File: rtl/spart_pkg.sv
// Shared definitions for the parametrised SPART transmitter: parity modes and
// the transmit state machine encoding.
package spart_pkg;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Mode 3 is reserved and behaves like PAR_NONE.
   function automatic logic parity_on(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/spart_tx_fifo.sv
// Small synchronous FIFO feeding the transmitter; the head is visible
// combinationally so the FSM can load it on the same edge it pops.
module spart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   // A full FIFO rejects a push even if a pop frees a slot on the same edge.
   assign full    = (count_reg == FULL_COUNT);
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/spart_tx_param.sv
// Parametrised SPART transmitter: queued characters are framed with optional
// parity and one or two stop bits, timed by the shared oversampling baud tick.
module spart_tx_param
   import spart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enable,
   input  logic                           write,
   input  logic [DATA_W-1:0]              data,
   input  logic [1:0]                     parity_mode,
   input  logic                           two_stop,
   output logic                           TxD,
   output logic                           TBR,
   output logic                           busy,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
   output logic                           overrun
);

   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = $clog2(DATA_W);
   localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

   tx_state_t         state_reg;
   logic [TW-1:0]     tick_reg;
   logic [BW-1:0]     bit_cnt_reg;
   logic [DATA_W-1:0] shift_reg;
   logic              parity_en_reg;
   logic              parity_bit_reg;
   logic              two_stop_reg;
   logic              txd_reg;
   logic              overrun_reg;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic [DATA_W-1:0] fifo_head;
   logic [DATA_W:0]   par_chain;
   logic              bit_end;
   logic              last_stop;

   spart_tx_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (write),
      .pop   (fifo_pop),
      .wdata (data),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign par_chain[0] = 1'b0;
   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ fifo_head[gi];
   end

   assign bit_end   = enable && (state_reg != IDLE) && (tick_reg == LAST_TICK);
   assign last_stop = (state_reg == STOP) && bit_end && (!two_stop_reg || (bit_cnt_reg != '0));
   // Popping at the end of the last stop bit chains frames with no idle gap.
   assign fifo_pop  = !fifo_empty && ((state_reg == IDLE) || last_stop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         tick_reg       <= '0;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         parity_en_reg  <= 1'b0;
         parity_bit_reg <= 1'b0;
         two_stop_reg   <= 1'b0;
         txd_reg        <= 1'b1;
      end else if (fifo_pop) begin
         state_reg      <= START;
         tick_reg       <= '0;
         bit_cnt_reg    <= '0;
         shift_reg      <= fifo_head;
         parity_en_reg  <= parity_on(parity_mode);
         parity_bit_reg <= par_chain[DATA_W] ^ (parity_mode == PAR_ODD);
         two_stop_reg   <= two_stop;
         txd_reg        <= 1'b0;
      end else if ((state_reg != IDLE) && enable) begin
         tick_reg <= bit_end ? '0 : tick_reg + 1'b1;
         if (bit_end) begin
            case (state_reg)
               START: begin
                  state_reg   <= DATA;
                  bit_cnt_reg <= '0;
                  txd_reg     <= shift_reg[0];
               end
               DATA: begin
                  if (bit_cnt_reg == LAST_BIT) begin
                     bit_cnt_reg <= '0;
                     if (parity_en_reg) begin
                        state_reg <= PARITY;
                        txd_reg   <= parity_bit_reg;
                     end else begin
                        state_reg <= STOP;
                        txd_reg   <= 1'b1;
                     end
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     shift_reg   <= shift_reg >> 1;
                     txd_reg     <= shift_reg[1];
                  end
               end
               PARITY: begin
                  state_reg   <= STOP;
                  bit_cnt_reg <= '0;
                  txd_reg     <= 1'b1;
               end
               STOP: begin
                  if (last_stop) begin
                     state_reg <= IDLE;
                     txd_reg   <= 1'b1;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  txd_reg   <= 1'b1;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_reg <= 1'b0;
      end else begin
         overrun_reg <= write && fifo_full;
      end
   end

   assign TxD     = txd_reg;
   assign TBR     = !fifo_full;
   assign busy    = (state_reg != IDLE) || (fifo_count != '0);
   assign overrun = overrun_reg;

endmodule

// File: tb/tb_spart_tx_param.sv
// Directed bench for spart_tx_param: a scoreboard of expected frames is filled
// on each accepted write and checked cycle by cycle against the serial line.
`timescale 1ns/1ps
module tb_spart_tx_param;

   localparam int OS = 16;

   typedef struct packed {
      logic [15:0] bits;
      logic [7:0]  nbits;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       write = 1'b0;
   logic       write2 = 1'b0;
   logic       two_stop = 1'b0;
   logic [7:0] data = 8'h00;
   logic [4:0] data2 = 5'h00;
   logic [1:0] parity_mode = 2'd0;

   logic       txd, tbr, busy, overrun;
   logic       txd2, tbr2, busy2, overrun2;
   logic [2:0] fifo_count;
   logic [1:0] fifo_count2;

   int en_div = 1;
   int div_cnt = 0;
   int n_checks = 0;
   int n_errors = 0;
   int frames_done[2] = '{0, 0};
   int b2b[2] = '{0, 0};
   frame_t sbq0[$];
   frame_t sbq1[$];

   spart_tx_param #(.DATA_W(8), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .enable(enable), .write(write), .data(data),
      .parity_mode(parity_mode), .two_stop(two_stop), .TxD(txd), .TBR(tbr),
      .busy(busy), .fifo_count(fifo_count), .overrun(overrun)
   );

   spart_tx_param #(.DATA_W(5), .OVERSAMPLE(OS), .FIFO_DEPTH(2)) dut5 (
      .clk(clk), .rst(rst), .enable(enable), .write(write2), .data(data2),
      .parity_mode(parity_mode), .two_stop(two_stop), .TxD(txd2), .TBR(tbr2),
      .busy(busy2), .fifo_count(fifo_count2), .overrun(overrun2)
   );

   always #5 clk = ~clk;

   // Baud tick: one pulse every en_div clocks, changed away from the active edge.
   always @(negedge clk) begin
      if (div_cnt >= en_div - 1) begin
         enable = 1'b1;
         div_cnt = 0;
      end else begin
         enable = 1'b0;
         div_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic frame_t make_frame(input logic [8:0] d, input int w,
                                         input logic [1:0] pm, input logic ts);
      frame_t f;
      int     n;
      logic   p;
      f.bits = '0;
      n = 1;
      p = 1'b0;
      for (int i = 0; i < w; i++) begin
         f.bits[n] = d[i];
         p ^= d[i];
         n++;
      end
      if (pm == 2'd1 || pm == 2'd2) begin
         f.bits[n] = (pm == 2'd2) ? ~p : p;
         n++;
      end
      f.bits[n] = 1'b1;
      n++;
      if (ts) begin
         f.bits[n] = 1'b1;
         n++;
      end
      f.nbits = 8'(n);
      return f;
   endfunction

   // Mode inputs are held stable from a write until its frame starts, so the
   // expectation can be built at write time.
   task automatic write_byte(input int which, input logic [8:0] d, input logic expect_ok);
      if (which == 0) begin
         data = d[7:0];
         write = 1'b1;
         check("tbr_before_write", tbr, expect_ok);
         if (expect_ok) sbq0.push_back(make_frame(d, 8, parity_mode, two_stop));
      end else begin
         data2 = d[4:0];
         write2 = 1'b1;
         check("tbr5_before_write", tbr2, expect_ok);
         if (expect_ok) sbq1.push_back(make_frame(d, 5, parity_mode, two_stop));
      end
      @(negedge clk);
      write = 1'b0;
      write2 = 1'b0;
      check("overrun_after_write", (which == 0) ? overrun : overrun2, !expect_ok);
   endtask

   task automatic run_monitor(input int which);
      frame_t      f;
      int          n;
      int          mism;
      logic [15:0] obs;
      bit          active;
      bit          just_ended;
      logic        en_s;
      logic        txv;
      string       name;
      name = (which == 0) ? "dut8" : "dut5";
      f = '0;
      n = 0;
      mism = 0;
      obs = '0;
      active = 0;
      just_ended = 0;
      forever begin
         @(posedge clk);
         en_s = enable;
         @(negedge clk);
         txv = (which == 0) ? txd : txd2;
         if (rst) begin
            active = 0;
            just_ended = 0;
         end else begin
            if (active) begin
               if (en_s) n++;
               if (n == int'(f.nbits) * OS) begin
                  check({name, " frame_bits"}, 32'(obs), 32'(f.bits));
                  check({name, " frame_timing_bad_cycles"}, mism, 0);
                  frames_done[which]++;
                  active = 0;
                  just_ended = 1;
               end else begin
                  if (txv !== f.bits[n / OS]) mism++;
                  if (n % OS == OS / 2) obs[n / OS] = txv;
               end
            end
            if (!active) begin
               if (txv === 1'b0) begin
                  check({name, " frame_expected"},
                        ((which == 0) ? sbq0.size() : sbq1.size()) != 0, 1'b1);
                  if (which == 0 && sbq0.size() != 0) f = sbq0.pop_front();
                  else if (which == 1 && sbq1.size() != 0) f = sbq1.pop_front();
                  else f = {16'h0000, 8'd1};
                  if (just_ended) b2b[which]++;
                  n = 0;
                  mism = 0;
                  obs = '0;
                  active = 1;
               end
               just_ended = 0;
            end
         end
      end
   endtask

   initial run_monitor(0);
   initial run_monitor(1);

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while ((busy || busy2) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({tag, " idle_timeout"}, busy | busy2, 1'b0);
      repeat (4) @(negedge clk);
   endtask

   task automatic measure_busy(input int which, input int budget, output int cyc);
      cyc = 0;
      while (((which == 0) ? busy : busy2) && cyc < budget) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic wait_txd(input logic level, input int budget, input string tag);
      int k = 0;
      while (txd !== level && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({tag, " wait_txd"}, txd, level);
   endtask

   task automatic count_level(input logic level, input int budget, output int cyc);
      cyc = 0;
      while (txd === level && cyc < budget) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int fd0;
      int bb0;
      int lows;
      int busys;

      repeat (3) @(negedge clk);
      check("rst TxD", txd, 1'b1);
      check("rst TBR", tbr, 1'b1);
      check("rst busy", busy, 1'b0);
      check("rst fifo_count", fifo_count, 3'd0);
      check("rst overrun", overrun, 1'b0);
      check("rst TxD5", txd2, 1'b1);
      check("rst fifo_count5", fifo_count2, 2'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // 0x55, 8N1, enable every clock
      write_byte(0, 9'h055, 1'b1);
      check("t1 count_after_write", fifo_count, 3'd1);
      check("t1 txd_before_pop", txd, 1'b1);
      check("t1 busy_queued", busy, 1'b1);
      @(negedge clk);
      check("t1 count_after_pop", fifo_count, 3'd0);
      check("t1 start_bit", txd, 1'b0);
      measure_busy(0, 400, cyc);
      check("t1 frame_cycles", cyc, 160);
      wait_idle(50, "t1");

      // 0x03 with even then odd parity, two stop bits
      two_stop = 1'b1;
      parity_mode = 2'd1;
      write_byte(0, 9'h003, 1'b1);
      @(negedge clk);
      measure_busy(0, 400, cyc);
      check("t2 even_frame_cycles", cyc, 192);
      wait_idle(50, "t2e");
      parity_mode = 2'd2;
      write_byte(0, 9'h003, 1'b1);
      @(negedge clk);
      measure_busy(0, 400, cyc);
      check("t2 odd_frame_cycles", cyc, 192);
      wait_idle(50, "t2o");

      // burst of five, sixth dropped, frames chained back to back
      two_stop = 1'b0;
      parity_mode = 2'd0;
      fd0 = frames_done[0];
      bb0 = b2b[0];
      for (int i = 0; i < 5; i++) begin
         write_byte(0, 9'(8'h3C + 8'(i * 37)), 1'b1);
      end
      write_byte(0, 9'h0FF, 1'b0);
      check("t3 fifo_full_count", fifo_count, 3'd4);
      check("t3 tbr_full", tbr, 1'b0);
      @(negedge clk);
      check("t3 overrun_one_cycle", overrun, 1'b0);
      wait_idle(1000, "t3");
      check("t3 frames_sent", frames_done[0] - fd0, 5);
      check("t3 back_to_back", b2b[0] - bb0, 4);

      // slow tick and a mid-frame parity change
      en_div = 3;
      parity_mode = 2'd1;
      write_byte(0, 9'h055, 1'b1);
      wait_txd(1'b0, 20, "t4 start");
      wait_txd(1'b1, 200, "t4 bit0");
      count_level(1'b1, 200, cyc);
      check("t4 bit0_clocks", cyc, 48);
      count_level(1'b0, 200, cyc);
      check("t4 bit1_clocks", cyc, 48);
      parity_mode = 2'd2;
      wait_idle(2000, "t4");
      parity_mode = 2'd0;
      en_div = 1;
      repeat (4) @(negedge clk);

      // reset during a data bit with two characters queued
      write_byte(0, 9'h000, 1'b1);
      write_byte(0, 9'h0A5, 1'b1);
      write_byte(0, 9'h05A, 1'b1);
      check("t5 queued", fifo_count, 3'd2);
      repeat (40) @(negedge clk);
      check("t5 mid_data_low", txd, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("t5 rst_txd", txd, 1'b1);
      check("t5 rst_count", fifo_count, 3'd0);
      check("t5 rst_busy", busy, 1'b0);
      check("t5 rst_tbr", tbr, 1'b1);
      sbq0.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      lows = 0;
      busys = 0;
      repeat (300) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
         if (busy !== 1'b0) busys++;
      end
      check("t5 no_frames_after_reset", lows, 0);
      check("t5 idle_after_reset", busys, 0);

      // 5-bit instance
      write_byte(1, 9'h01F, 1'b1);
      @(negedge clk);
      check("t6 count5_after_pop", fifo_count2, 2'd0);
      check("t6 start_bit5", txd2, 1'b0);
      measure_busy(1, 400, cyc);
      check("t6 frame5_cycles", cyc, 112);
      wait_idle(50, "t6");

      check("sb0 drained", sbq0.size(), 0);
      check("sb1 drained", sbq1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
